// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard unit: tracks in-flight destination registers, selects
// forwarding sources, raises load-use stalls and counts stall/flush events.
module pipe_hazard_unit #(
  parameter int unsigned AW         = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CW         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [AW-1:0]                  id_rs1,
  input  logic [AW-1:0]                  id_rs2,
  input  logic                           id_rs1_use,
  input  logic                           id_rs2_use,
  input  logic [AW-1:0]                  id_rd,
  input  logic                           id_wr_en,
  input  logic                           id_is_load,
  input  logic                           flush,
  input  logic                           clr_cnt,
  output logic                           stall,
  output logic                           issue,
  output logic [$clog2(DEPTH+1)-1:0]     fwd1_sel,
  output logic [$clog2(DEPTH+1)-1:0]     fwd2_sel,
  output logic [CW-1:0]                  stall_cnt,
  output logic [CW-1:0]                  flush_cnt
);

  localparam int unsigned SW = $clog2(DEPTH+1);

  // Tracker: index 0 is stage 1 (EX), index DEPTH-1 is writeback.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];
  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]    flush_cnt_q, flush_cnt_d;

  logic          hit1, hit2, haz1, haz2, rdy, hazard;
  logic [SW-1:0] sel1, sel2;

  // Youngest-match lookup per source and stall/issue decision.
  always_comb begin
    sel1   = '0;
    sel2   = '0;
    hit1   = 1'b0;
    hit2   = 1'b0;
    haz1   = 1'b0;
    haz2   = 1'b0;
    rdy    = 1'b0;
    hazard = 1'b0;
    stall  = 1'b0;
    issue  = 1'b0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      rdy = !ld_q[s] || ((s + 1) >= LOAD_READY);
      if (!hit1 && id_rs1_use && (id_rs1 != '0) && vld_q[s] && (rd_q[s] == id_rs1)) begin
        hit1 = 1'b1;
        sel1 = rdy ? SW'(s + 1) : '0;
        haz1 = !rdy;
      end
      if (!hit2 && id_rs2_use && (id_rs2 != '0) && vld_q[s] && (rd_q[s] == id_rs2)) begin
        hit2 = 1'b1;
        sel2 = rdy ? SW'(s + 1) : '0;
        haz2 = !rdy;
      end
    end
    hazard = id_valid && (haz1 || haz2);
    if (!rst) begin
      stall = 1'b0;
      issue = id_valid;
    end else begin
      stall = hazard && !flush;
      issue = id_valid && !stall && !flush;
    end
  end

  assign fwd1_sel  = sel1;
  assign fwd2_sel  = sel2;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Tracker shift and saturating counters.
  always_comb begin
    vld_d    = '0;
    ld_d     = '0;
    for (int unsigned s = 0; s < DEPTH; s++) rd_d[s] = '0;
    vld_d[0] = issue && id_wr_en && (id_rd != '0);
    rd_d[0]  = id_rd;
    ld_d[0]  = id_is_load;
    for (int unsigned s = 1; s < DEPTH; s++) begin
      vld_d[s] = vld_q[s-1];
      rd_d[s]  = rd_q[s-1];
      ld_d[s]  = ld_q[s-1];
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
      if (flush && id_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      ld_q        <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) rd_q[s] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      ld_q        <= ld_d;
      for (int unsigned s = 0; s < DEPTH; s++) rd_q[s] <= rd_d[s];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: per-cycle expected stall/issue/forward values are
// queued as stimulus is applied and compared by a scoreboard on the falling edge.
module tb_pipe_hazard_unit;

  localparam int unsigned AW         = 5;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned LOAD_READY = 2;
  localparam int unsigned CW         = 4;
  localparam int unsigned SW         = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs1_use, id_rs2_use, id_wr_en, id_is_load, flush, clr_cnt;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          stall, issue;
  logic [SW-1:0] fwd1_sel, fwd2_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string         tag;
    logic          stall;
    logic          issue;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  pipe_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rs1_use(id_rs1_use),
    .id_rs2_use(id_rs2_use),
    .id_rd     (id_rd),
    .id_wr_en  (id_wr_en),
    .id_is_load(id_is_load),
    .flush     (flush),
    .clr_cnt   (clr_cnt),
    .stall     (stall),
    .issue     (issue),
    .fwd1_sel  (fwd1_sel),
    .fwd2_sel  (fwd2_sel),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare combinational outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      checks++;
      if (stall !== cur.stall) begin
        errors++;
        $display("FAIL %s stall: got %0b expected %0b", cur.tag, stall, cur.stall);
      end
      checks++;
      if (issue !== cur.issue) begin
        errors++;
        $display("FAIL %s issue: got %0b expected %0b", cur.tag, issue, cur.issue);
      end
      checks++;
      if (fwd1_sel !== cur.s1) begin
        errors++;
        $display("FAIL %s fwd1_sel: got %0d expected %0d", cur.tag, fwd1_sel, cur.s1);
      end
      checks++;
      if (fwd2_sel !== cur.s2) begin
        errors++;
        $display("FAIL %s fwd2_sel: got %0d expected %0d", cur.tag, fwd2_sel, cur.s2);
      end
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2, input logic [AW-1:0] rd,
                       input logic wr, input logic ld, input logic fl);
    id_valid   = v;
    id_rs1     = rs1;
    id_rs1_use = u1;
    id_rs2     = rs2;
    id_rs2_use = u2;
    id_rd      = rd;
    id_wr_en   = wr;
    id_is_load = ld;
    flush      = fl;
  endtask

  task automatic push_exp(input string tag, input logic st, input logic is, input int s1, input int s2);
    exp_t e;
    e.tag   = tag;
    e.stall = st;
    e.issue = is;
    e.s1    = SW'(s1);
    e.s2    = SW'(s2);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    push_exp("reset_outs", 1'b0, 1'b1, 0, 0);
    checks++;
    if (stall_cnt !== CW'(0) || flush_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_forward();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    push_exp("fwd_issue", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("fwd_s1", 1'b0, 1'b1, 1, 0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("fwd_s2", 1'b0, 1'b1, 2, 2);
    tick();
    push_exp("fwd_s3", 1'b0, 1'b1, 3, 3);
    tick();
    push_exp("fwd_wb", 1'b0, 1'b1, 4, 4);
    tick();
    push_exp("fwd_retired", 1'b0, 1'b1, 0, 0);
    tick();
    idle(1);
  endtask

  task automatic test_load_use();
    clear_counters();
    checks++;
    if (stall_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL lu_cnt_clr: got %0d expected 0", stall_cnt);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    push_exp("lu_issue", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    push_exp("lu_stall", 1'b1, 1'b0, 0, 0);
    tick();
    checks++;
    if (stall_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL lu_cnt: got %0d expected 1", stall_cnt);
    end
    push_exp("lu_fwd", 1'b0, 1'b1, 0, 2);
    tick();
    idle(DEPTH);
    checks++;
    if (stall_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL lu_cnt_hold: got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    push_exp("yg_old", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("yg_bubble", 1'b0, 1'b0, 0, 0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    push_exp("yg_new", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("yg_pick", 1'b0, 1'b1, 1, 1);
    tick();
    idle(DEPTH);
    // Older ready ALU result must not hide a younger unready load.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    push_exp("yl_alu", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("yl_bubble", 1'b0, 1'b0, 0, 0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    push_exp("yl_load", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("yl_stall", 1'b1, 1'b0, 0, 0);
    tick();
    push_exp("yl_fwd", 1'b0, 1'b1, 2, 0);
    tick();
    idle(DEPTH);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    push_exp("x0_issue", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("x0_read", 1'b0, 1'b1, 0, 0);
    tick();
    idle(DEPTH);
  endtask

  task automatic test_flush();
    clear_counters();
    checks++;
    if (flush_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL fl_cnt_clr: got %0d expected 0", flush_cnt);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    push_exp("fl_load", 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    push_exp("fl_haz", 1'b0, 1'b0, 0, 0);
    tick();
    checks++;
    if (flush_cnt !== CW'(1) || stall_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL fl_cnt: got flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt);
    end
    drive(1'b1, 5'd10, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("fl_squashed", 1'b0, 1'b1, 0, 2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push_exp("fl_novalid", 1'b0, 1'b0, 0, 0);
    tick();
    checks++;
    if (flush_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL fl_cnt_novalid: got %0d expected 1", flush_cnt);
    end
    idle(DEPTH);
  endtask

  task automatic test_saturation();
    clear_counters();
    // lw x6,(x6) held in decode: alternates issue and load-use stall.
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin
        checks++;
        if (stall_cnt !== CW'(5)) begin
          errors++;
          $display("FAIL sat_mid: got %0d expected 5", stall_cnt);
        end
      end
      if (i == 38) begin
        checks++;
        if (stall_cnt !== CW'(15)) begin
          errors++;
          $display("FAIL sat_max: got %0d expected 15", stall_cnt);
        end
      end
      clr_cnt = (i == 39);
      drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      if (i % 2 == 1) push_exp("sat_stall", 1'b1, 1'b0, 0, 0);
      else            push_exp("sat_issue", 1'b0, 1'b1, (i > 0) ? 2 : 0, 0);
      tick();
    end
    clr_cnt = 1'b0;
    checks++;
    if (stall_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL sat_clr: got %0d expected 0", stall_cnt);
    end
    idle(DEPTH);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push_exp("rm_flush", 1'b0, 1'b0, 0, 0);
    tick();
    for (int r = 11; r <= 13; r++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, AW'(r), 1'b1, 1'b0, 1'b0);
      push_exp("rm_fill", 1'b0, 1'b1, 0, 0);
      tick();
    end
    checks++;
    if (flush_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL rm_pre_cnt: got %0d expected 1", flush_cnt);
    end
    rst = 1'b0;
    drive(1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("rm_in_reset", 1'b0, 1'b1, 0, 0);
    #1;
    checks++;
    if (stall_cnt !== CW'(0) || flush_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL rm_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    rst = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push_exp("rm_released", 1'b0, 1'b1, 0, 0);
    tick();
    idle(2);
  endtask

  initial begin
    rst     = 1'b0;
    clr_cnt = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_youngest();
    test_flush();
    test_saturation();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 The block SHALL take parameter AW, default 5: register-address width, giving 2^AW architectural registers.
REQ-002 The block SHALL take parameter DEPTH, default 4: number of tracked stages after decode (stage 1 = EX … stage DEPTH = writeback). Legal range is 2..8.
REQ-003 The block SHALL take parameter LOAD_READY, default 2: first stage at which a load result is forwardable. Legal range is 1..DEPTH.
REQ-004 The block SHALL take parameter CW, default 16: performance-counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port id_valid, input, 1 bit: decode stage holds a valid instruction.
REQ-008 Ports id_rs1, id_rs2, input, AW bits each: source register addresses.
REQ-009 Ports id_rs1_use, id_rs2_use, input, 1 bit each: the corresponding source is read.
REQ-010 Port id_rd, input, AW bits: destination register.
REQ-011 Port id_wr_en, input, 1 bit: the instruction writes rd.
REQ-012 Port id_is_load, input, 1 bit: the instruction is a load.
REQ-013 Port flush, input, 1 bit: taken branch/jump; squash the decode instruction.
REQ-014 Port clr_cnt, input, 1 bit: synchronous clear of both counters.
REQ-015 Port stall, output, 1 bit: hold IF/ID and inject a bubble into stage 1.
REQ-016 Port issue, output, 1 bit: the decode instruction enters stage 1 this cycle.
REQ-017 Ports fwd1_sel, fwd2_sel, output, SW = clog2(DEPTH+1) bits each: 0 = register file, s = stage-s result.
REQ-018 Ports stall_cnt, flush_cnt, output, CW bits each: saturating event counters.

Function
REQ-019 The tracker SHALL hold DEPTH entries {valid, rd, is_load} that shift from stage s to s+1 every cycle, unconditionally; the stage-DEPTH entry retires.
REQ-020 Stage 1 SHALL load valid = issue & id_wr_en & (id_rd != 0), together with rd = id_rd and is_load = id_is_load; a bubble loads valid = 0.
REQ-021 A stage-s entry SHALL be data-ready when is_load = 0, or when is_load = 1 and s >= LOAD_READY.
REQ-022 Per source, match SHALL be (use = 1) & (rs != 0) & (entry valid) & (entry rd = rs), and the youngest (lowest s) match SHALL win.
REQ-023 fwdN_sel SHALL equal the stage of the winning match if that entry is data-ready, else 0. With no match it SHALL be 0. It is combinational from the inputs and tracker state.
REQ-024 Hazard SHALL be id_valid & (either source's winning match not data-ready). Older ready matches do not suppress a hazard from a younger unready one.
REQ-025 stall SHALL equal hazard & ~flush; flush has priority over stall.
REQ-026 issue SHALL equal id_valid & ~stall & ~flush.
REQ-027 stall_cnt SHALL increment in each cycle with stall = 1.
REQ-028 flush_cnt SHALL increment in each cycle with flush & id_valid.
REQ-029 Both counters SHALL saturate at 2^CW-1 without wrap.
REQ-030 clr_cnt SHALL zero both counters on the next edge and has priority over increment.
REQ-031 Register x0 SHALL never be tracked nor forwarded.
REQ-032 Simultaneous retire at stage DEPTH and a new match SHALL be handled within a single cycle; the register file is not write-through, so the stage-DEPTH entry remains forwardable.

Reset
REQ-033 While rst = 0, all tracker entries SHALL be invalid and stall_cnt = flush_cnt = 0, asynchronously.
REQ-034 While rst = 0, outputs SHALL be stall = 0, fwd1_sel = fwd2_sel = 0, and issue = id_valid.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries; there is no stall after release.

Verification
REQ-036 Forwarding: issue add x5 at cycle 0; at cycle 1 decode rs1 = x5 -> fwd1_sel = 1, stall = 0; at cycle 2 the same rs1 -> fwd1_sel = 2.
REQ-037 Load-use: lw x6 at cycle 0; at cycle 1 rs2 = x6 -> stall = 1, issue = 0; at cycle 2 -> stall = 0, fwd2_sel = 2, stall_cnt = 1.
REQ-038 Youngest priority: writes to x7 at stages 1 and 3, decode rs1 = rs2 = x7 -> both sels = 1. The x0 case: rd = x0 issued, next rs1 = x0 -> fwd1_sel = 0.
REQ-039 Flush vs hazard: load-use hazard with flush = 1 -> stall = 0, issue = 0, stage 1 invalid next cycle, flush_cnt += 1.
REQ-040 Saturation/clear: CW = 4, hold the stall condition for 20 cycles -> stall_cnt = 15; then clr_cnt = 1 together with stall -> 0.
REQ-041 Reset mid-stream: three valid entries, rst = 0 for one cycle -> all sels 0, counters 0, and rs matching the old rd after release gives no forward.
